// File: rtl/data_bus_responder_if.sv
// Data-memory port between the core and data_bus_responder, plus the console
// byte stream and the sticky fault flag.
//   data_addr/data_wdata/data_re/data_we : core -> responder access
//   data_rdata                           : responder -> core, combinational
//   tx_valid/tx_data                     : responder -> console sink
//   tx_ready                             : console sink -> responder
//   fault                                : sticky bus fault flag
interface data_bus_responder_if;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_re;
  logic        data_we;
  logic [31:0] data_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        fault;

  modport master (
    output data_addr, data_wdata, data_re, data_we, tx_ready,
    input  data_rdata, tx_valid, tx_data, fault
  );

  modport slave (
    input  data_addr, data_wdata, data_re, data_we, tx_ready,
    output data_rdata, tx_valid, tx_data, fault
  );
endinterface

// File: rtl/data_bus_responder.sv
// Responder for the core's data-memory port. Decodes word accesses to a RAM
// or to a 16-byte MMIO block (CYCLE, TX_DATA, STATUS, SCRATCH). Reads are
// combinational so a single-cycle core never stalls. TX_DATA writes feed a
// small FIFO drained as a paced byte stream towards the console sink.
// Ports:
//   clk_i   : clock, rising edge
//   reset_i : asynchronous, active-high reset
//   bus     : slave side of data_bus_responder_if (core port, console, fault)
module data_bus_responder #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TX_DIV     = 8
) (
  input logic                  clk_i,
  input logic                  reset_i,
  data_bus_responder_if.slave  bus
);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam logic [31:0] RAM_SPAN = 32'(MEM_WORDS * 4);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PACE_LOAD = PW'(TX_DIV - 1);

  logic [31:0] ram [MEM_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  logic [31:0]     cycle_q;
  logic [31:0]     scratch_q;
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   pace_q;
  logic            ovf_q, fault_q;

  // Offsets relative to each base; an address below a base wraps to a large
  // value and so falls out of range without a separate lower-bound compare.
  logic [31:0] ram_off, mmio_off;
  logic        ram_hit, mmio_hit, acc_fault;
  logic [AW-1:0] ram_idx;
  logic [1:0]  mmio_sel;
  logic        empty, full, pop, push_req, push, ovf_set, status_we;
  logic [31:0] status;

  always_comb begin
    ram_off   = bus.data_addr - RAM_BASE;
    mmio_off  = bus.data_addr - MMIO_BASE;
    ram_hit   = ram_off < RAM_SPAN;
    mmio_hit  = mmio_off < 32'd16;
    acc_fault = (bus.data_addr[1:0] != 2'b00) || !(ram_hit || mmio_hit);
    ram_idx   = ram_off[AW+1:2];
    mmio_sel  = mmio_off[3:2];

    empty     = (count_q == '0);
    full      = (count_q == DEPTH_C);
    pop       = !empty && (pace_q == '0) && bus.tx_ready;
    push_req  = bus.data_we && !acc_fault && !ram_hit && (mmio_sel == 2'd1);
    // A push into a full FIFO is still accepted when a pop frees a slot.
    push      = push_req && (!full || pop);
    ovf_set   = push_req && full && !pop;
    status_we = bus.data_we && !acc_fault && !ram_hit && (mmio_sel == 2'd2);
    status    = {22'b0, fault_q, ovf_q, 6'(count_q), full, empty};
  end

  always_comb begin
    bus.data_rdata = '0;
    if (bus.data_re && !acc_fault) begin
      if (ram_hit) begin
        bus.data_rdata = ram[ram_idx];
      end else begin
        case (mmio_sel)
          2'd0:    bus.data_rdata = cycle_q;
          2'd2:    bus.data_rdata = status;
          2'd3:    bus.data_rdata = scratch_q;
          default: bus.data_rdata = '0;
        endcase
      end
    end
  end

  assign bus.tx_valid = !empty && (pace_q == '0);
  assign bus.tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign bus.fault    = fault_q;

  always_ff @(posedge clk_i) begin
    if (bus.data_we && !acc_fault && ram_hit) begin
      ram[ram_idx] <= bus.data_wdata;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cycle_q   <= '0;
      scratch_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pace_q    <= '0;
      ovf_q     <= 1'b0;
      fault_q   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      cycle_q <= cycle_q + 32'd1;

      if (bus.data_we && !acc_fault && !ram_hit && (mmio_sel == 2'd3)) begin
        scratch_q <= bus.data_wdata;
      end

      if (push) begin
        fifo_q[wr_ptr_q] <= bus.data_wdata[7:0];
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (pop) begin
        pace_q <= PACE_LOAD;
      end else if (pace_q != '0) begin
        pace_q <= pace_q - 1'b1;
      end

      // Set has priority over a simultaneous write-one-to-clear.
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (status_we && bus.data_wdata[8]) begin
        ovf_q <= 1'b0;
      end

      if ((bus.data_re || bus.data_we) && acc_fault) begin
        fault_q <= 1'b1;
      end else if (status_we && bus.data_wdata[9]) begin
        fault_q <= 1'b0;
      end
    end
  end
endmodule
